// File: rtl/comm_pkg.sv
// Shared types and constants for the CommMaster request arbiter.
package comm_pkg;

    localparam int CMD_W = 16;
    localparam logic [7:0] ACK = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_CMPLT,
        WAIT_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: searches from ptr+1 upward, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      idx
);

    logic found;
    int   pos;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[pos]) begin
                found       = 1'b1;
                winner[pos] = 1'b1;
                idx         = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/comm_arbiter.sv
// Shares the CommMaster transmitter among NUM_REQ requesters and waits for the ACK byte.
// Define COMM_ARB_RETRY_EN to resend a failed command up to MAX_RETRY times.
module comm_arbiter
    import comm_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [CMD_W*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     ok,
    output logic                     busy,
    output logic                     send_cmd,
    output logic [CMD_W-1:0]         cmd,
    input  logic                     cmd_cmplt,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic                     clr_resp_rdy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || MAX_RETRY < 0) begin : g_bad_param
        $error("comm_arbiter: parameter out of range");
    end

    arb_state_t        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     cur;
    logic [CW-1:0]     tcnt;
    logic              clr_send;
    logic [NUM_REQ-1:0] win;
    logic [IW-1:0]     win_idx;
    logic              in_resp;
    logic              tmo;
    logic              fail;
    logic              retry;
    logic              finish;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .idx    (win_idx)
    );

    // A response arriving on the last allowed cycle beats the timeout.
    assign in_resp = (state == WAIT_RESP);
    assign tmo     = in_resp && !resp_rdy && (tcnt == CW'(TIMEOUT_CYC - 1));
    assign fail    = (in_resp && resp_rdy && (resp != ACK)) || tmo;

`ifdef COMM_ARB_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_cnt;
    assign retry = fail && (retry_cnt < RW'(MAX_RETRY));
`else
    assign retry = 1'b0;
`endif

    assign finish       = in_resp && (resp_rdy || tmo) && !retry;
    assign done         = finish ? gnt : '0;
    assign ok           = finish && resp_rdy && (resp == ACK);
    assign clr_resp_rdy = clr_send | (in_resp & resp_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= IW'(NUM_REQ - 1);
            cur      <= '0;
            gnt      <= '0;
            cmd      <= '0;
            busy     <= 1'b0;
            send_cmd <= 1'b0;
            clr_send <= 1'b0;
            tcnt     <= '0;
`ifdef COMM_ARB_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            send_cmd <= 1'b0;
            clr_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= LOAD;
                        gnt   <= win;
                        cur   <= win_idx;
                        cmd   <= req_cmd[int'(win_idx)*CMD_W +: CMD_W];
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    ptr      <= cur;
                    send_cmd <= 1'b1;
                    clr_send <= 1'b1;
                    state    <= SEND;
`ifdef COMM_ARB_RETRY_EN
                    retry_cnt <= '0;
`endif
                end
                SEND: begin
                    tcnt  <= '0;
                    state <= WAIT_CMPLT;
                end
                WAIT_CMPLT: begin
                    if (cmd_cmplt) state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (tcnt != CW'(TIMEOUT_CYC)) tcnt <= tcnt + 1'b1;
                    if (retry) begin
                        send_cmd <= 1'b1;
                        clr_send <= 1'b1;
                        state    <= SEND;
`ifdef COMM_ARB_RETRY_EN
                        retry_cnt <= retry_cnt + 1'b1;
`endif
                    end else if (finish) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
